// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response handshake bundle between an initiator and mem_responder
interface mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word memory with fixed wait latency
// Optional byte-lane stores enabled by defining MEM_RESPONDER_BYTE_LANE_EN.
module mem_responder #(
   parameter int DEPTH = 1024,
   parameter int WAIT  = 2
) (
   input  logic            clock,
   input  logic            reset,
   mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];

   logic          cur_we;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [3:0]    cur_be;
   logic [AW-1:0] cur_idx;
   logic          cur_err;
   logic [3:0]    lane_mask;
   logic          go_resp;
   logic          wr_en;
   logic [31:0]   wr_word;

   // With WAIT=0 the request goes straight to RESP, so commit from the live inputs.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_we    = bus.req_we;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
         cur_be    = bus.req_be;
      end else begin
         cur_we    = we_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_be    = be_q;
      end
      cur_idx = cur_addr[AW+1:2];
      cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
`ifdef MEM_RESPONDER_BYTE_LANE_EN
      lane_mask = cur_be;
`else
      lane_mask = cur_be | 4'hF;
`endif
      for (int i = 0; i < 4; i++) begin
         wr_word[8*i +: 8] = lane_mask[i] ? cur_wdata[8*i +: 8] : mem_q[cur_idx][8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      go_resp = 1'b0;
      wr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               if (WAIT == 0) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (go_resp) begin
         err_d   = cur_err;
         rdata_d = (!cur_we && !cur_err) ? mem_q[cur_idx] : 32'd0;
         wr_en   = cur_we && !cur_err;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (wr_en) begin
            mem_q[cur_idx] <= wr_word;
         end
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (DEPTH=1024, WAIT=2)
module tb_mem_responder;
   logic clock;
   logic reset;
   int   checks;
   int   failures;

   mem_responder_if mif ();

   mem_responder #(.DEPTH(1024), .WAIT(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (mif.slave)
   );

`ifdef MEM_RESPONDER_BYTE_LANE_EN
   localparam logic [31:0] EXP_MERGE = 32'hDE22BE44;
`else
   localparam logic [31:0] EXP_MERGE = 32'h11223344;
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts and ends on a falling edge; leaves the response pending when rsp_ready is 0.
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic e,
                         output int lat);
      mif.req_valid = 1'b1;
      mif.req_we    = we;
      mif.req_addr  = a;
      mif.req_wdata = d;
      mif.req_be    = be;
      @(posedge clock);
      @(negedge clock);
      mif.req_valid = 1'b0;
      lat = 1;
      while (!mif.rsp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd = mif.rsp_rdata;
      e  = mif.rsp_err;
      if (mif.rsp_ready) @(negedge clock);
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;

      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      mif.req_valid = 1'b0;
      mif.req_we    = 1'b0;
      mif.req_addr  = 32'd0;
      mif.req_wdata = 32'd0;
      mif.req_be    = 4'd0;
      mif.rsp_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_req_ready", mif.req_ready, 1);
      check("rst_rsp_valid", mif.rsp_valid, 0);
      check("rst_rdata", mif.rsp_rdata, 0);
      check("rst_err", mif.rsp_err, 0);

      do_req(1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat);
      check("ld0_latency", 32'(lat), 3);
      check("ld0_rdata", rd, 32'h0);
      check("ld0_err", e, 0);

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
      check("st10_latency", 32'(lat), 3);
      check("st10_rdata", rd, 32'h0);
      check("st10_err", e, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
      check("ld10_rdata", rd, 32'hDEADBEEF);

      do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e, lat);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
      check("ld10_merge", rd, EXP_MERGE);

      do_req(1'b0, 32'h13, 32'h0, 4'hF, rd, e, lat);
      check("ld13_err", e, 1);
      check("ld13_rdata", rd, 32'h0);
      check("ld13_latency", 32'(lat), 3);
      do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, e, lat);
      check("st1000_err", e, 1);
      check("st1000_rdata", rd, 32'h0);
      do_req(1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat);
      check("ld0_unchanged", rd, 32'h0);
      check("ld0_unchanged_err", e, 0);

      mif.rsp_ready = 1'b0;
      do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
      check("bp_first_rdata", rd, EXP_MERGE);
      mif.req_valid = 1'b1;
      mif.req_we    = 1'b1;
      mif.req_addr  = 32'h10;
      mif.req_wdata = 32'h99999999;
      mif.req_be    = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_rsp_valid", mif.rsp_valid, 1);
         check("bp_rdata", mif.rsp_rdata, EXP_MERGE);
         check("bp_req_ready", mif.req_ready, 0);
      end
      mif.req_valid = 1'b0;
      mif.rsp_ready = 1'b1;
      @(negedge clock);
      check("bp_release_valid", mif.rsp_valid, 0);
      check("bp_release_ready", mif.req_ready, 1);
      check("bp_release_rdata", mif.rsp_rdata, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
      check("bp_ignored_store", rd, EXP_MERGE);

      mif.req_valid = 1'b1;
      mif.req_we    = 1'b1;
      mif.req_addr  = 32'h20;
      mif.req_wdata = 32'h55;
      mif.req_be    = 4'hF;
      @(posedge clock);
      @(negedge clock);
      mif.req_valid = 1'b0;
      check("wait_req_ready", mif.req_ready, 0);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("abort_req_ready", mif.req_ready, 1);
      check("abort_rsp_valid", mif.rsp_valid, 0);
      do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
      check("abort_ld20", rd, 32'h0);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
      check("rst_cleared_ld10", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL provide parameter DEPTH, default 1024, meaning the number of 32-bit words in the storage array (power of two, 16..4096).
REQ-002 The module SHALL provide parameter WAIT, default 2, meaning the number of wait cycles inserted between request acceptance and response (0..15).
REQ-003 The module SHALL have port clock, input, 1, the single clock; all logic is rising-edge triggered.
REQ-004 The module SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The module SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-006 The module SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-007 The module SHALL have port req_we, input, 1, meaning 1 = store and 0 = load.
REQ-008 The module SHALL have port req_addr, input, 32, the byte address.
REQ-009 The module SHALL have port req_wdata, input, 32, the store data.
REQ-010 The module SHALL have port req_be, input, 4, the store byte-lane enables (bit i selects bits 8i+7..8i).
REQ-011 The module SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-012 The module SHALL have port rsp_ready, input, 1, meaning the initiator accepts the response.
REQ-013 The module SHALL have port rsp_rdata, output, 32, the load data (0 for stores and errors).
REQ-014 The module SHALL have port rsp_err, output, 1, meaning the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a clock edge with req_valid=1 and req_ready=1, at which point we, addr, wdata, and be are latched.
REQ-018 On acceptance with WAIT>0 the FSM SHALL enter WAIT, loading the wait counter with WAIT-1; with WAIT=0 it SHALL enter RESP directly.
REQ-019 In WAIT the counter SHALL decrement every cycle, and the FSM SHALL enter RESP on the edge where the counter equals 0.
REQ-020 rsp_valid SHALL rise exactly WAIT+1 cycles after the accepting edge.
REQ-021 On the edge entering RESP, a store SHALL commit to the array and a load SHALL capture the array word into rsp_rdata.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL be held stable until the edge with rsp_ready=1, on which the FSM returns to IDLE.
REQ-023 Minimum request-to-request spacing SHALL be WAIT+2 cycles, and requests presented outside IDLE SHALL be ignored (not queued).
REQ-024 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-025 The error condition SHALL be addr[1:0]!=0 or addr[31:log2(DEPTH)+2]!=0.
REQ-026 An error request SHALL perform no array write, SHALL return rsp_rdata=0 and rsp_err=1, and SHALL observe the same latency as a good request.
REQ-027 A load of a word written by an earlier completed store SHALL return the updated value.
REQ-028 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-029 On reset=1 at a clock edge the FSM SHALL go to IDLE, clear the wait counter, and clear every array word to 0.
REQ-030 After reset, outputs SHALL be req_ready=1, rsp_valid=0, rsp_rdata=0, and rsp_err=0.
REQ-031 Reset SHALL take priority over every other event, including a pending response in RESP.
REQ-032 A store in WAIT aborted by reset SHALL NOT reach the array.

Configuration
REQ-033 The module SHALL honour macro MEM_RESPONDER_BYTE_LANE_EN.
REQ-034 With MEM_RESPONDER_BYTE_LANE_EN defined, a store SHALL write only the lanes with req_be bit=1, and req_be=0000 SHALL complete normally with no array change.
REQ-035 With MEM_RESPONDER_BYTE_LANE_EN undefined, req_be SHALL be ignored and every store SHALL write all 32 bits.
REQ-036 Loads SHALL always return the full word regardless of MEM_RESPONDER_BYTE_LANE_EN.

Verification
REQ-037 The bench SHALL cover reset then a load of addr 0x0 with WAIT=2, rsp_ready=1 -> rsp_valid high 3 cycles after acceptance, rdata=0x00000000, err=0.
REQ-038 The bench SHALL cover a store of 0xDEADBEEF to 0x10 with be=1111, then a load of 0x10 -> rdata=0xDEADBEEF.
REQ-039 The bench SHALL cover, with the macro defined, a store of 0x11223344 to 0x10 with be=0101 over 0xDEADBEEF -> load returns 0xDE22BE44; with the macro undefined -> 0x11223344.
REQ-040 The bench SHALL cover a load of 0x13 and a store to 0x1000 at DEPTH=1024 -> rsp_err=1, rdata=0, and a following load of 0x0 unchanged.
REQ-041 The bench SHALL cover holding rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0, and a second req_valid ignored.
REQ-042 The bench SHALL cover asserting reset during WAIT of a store of 0x55 to 0x20 -> next cycle req_ready=1, rsp_valid=0, and a load of 0x20 returns 0.
